// File: rtl/c4_pkg.sv
// rtl/c4_pkg.sv - FSM state enum, C4 {s,t} state type and the C4 next-state function
package c4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_t;

  typedef logic [1:0] c4_state_t;

  localparam c4_state_t S00 = 2'b00;
  localparam c4_state_t S01 = 2'b01;
  localparam c4_state_t S11 = 2'b11;
  localparam c4_state_t S10 = 2'b10;

  function automatic c4_state_t c4_next(c4_state_t cur, logic a);
    c4_state_t nxt;
    case (cur)
      S00:     nxt = a ? S01 : S00;
      S01:     nxt = a ? S10 : S11;
      S11:     nxt = S00;
      default: nxt = a ? S10 : S00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/c4_model.sv
// rtl/c4_model.sv - registered C4 detector state {s,t}, advanced from the serial line every edge
module c4_model import c4_pkg::*; (
  input  logic n_clk,
  input  logic rst,
  input  logic a,
  output logic s,
  output logic t
);

  c4_state_t st;

  always_ff @(negedge n_clk or negedge rst) begin
    if (!rst) begin
      st <= S00;
    end else begin
      st <= c4_next(st, a);
    end
  end

  assign {s, t} = st;

endmodule

// File: rtl/c4_stim_tx.sv
// rtl/c4_stim_tx.sv - LSB-first serial stimulus transmitter for the C4 path
// C4_TX_MODEL_EN adds the c4_model instance and the exp_s/exp_t ports.
module c4_stim_tx import c4_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             n_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             a,
  output logic             busy,
  output logic             done
`ifdef C4_TX_MODEL_EN
  ,
  output logic             exp_s,
  output logic             exp_t
`endif
);

  localparam int CW = $clog2(WIDTH);
  // A zero-width gap counter is not legal, so GAP==0 keeps a single unused bit.
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  tx_state_t        state;
  tx_state_t        state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             bit_last;
  logic             gap_last;

  assign bit_last = (bit_cnt == BIT_LAST);
  assign gap_last = (gap_cnt == GAP_LAST);

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        done = bit_last;
        if (bit_last) state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        busy = 1'b1;
        if (gap_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(negedge n_clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      a       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (valid) begin
            shreg   <= data;
            bit_cnt <= '0;
            gap_cnt <= '0;
            a       <= data[0];
          end
        end
        ST_SHIFT: begin
          shreg <= shreg >> 1;
          // Counter saturates on the last bit; the line drops to 0 for GAP/IDLE.
          if (bit_last) begin
            a <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
            a       <= shreg[1];
          end
        end
        ST_GAP: begin
          a <= 1'b0;
          if (!gap_last) gap_cnt <= gap_cnt + GW'(1);
        end
        default: a <= 1'b0;
      endcase
    end
  end

`ifdef C4_TX_MODEL_EN
  c4_model u_model (
    .n_clk (n_clk),
    .rst   (rst),
    .a     (a),
    .s     (exp_s),
    .t     (exp_t)
  );
`endif

endmodule

// File: doc/c4_stim_tx.md
# c4_stim_tx

Serial stimulus transmitter for the C4 state-machine path. It accepts a parallel word through a valid/ready handshake and serialises it LSB-first onto the single-bit line `a`, which feeds the C4 detector input. An optional built-in C4 next-state model tracks the state `{s,t}` the detector must reach after each bit, so a bench or checker can compare the two directly.

## Interface
- `WIDTH`, default 8: data word width, ≥2.
- `GAP`, default 1: idle cycles, with `a`=0, after the last bit of each word, ≥0.

- `n_clk`: input, 1 bit. Clock; all registers update on its falling edge.
- `rst`: input, 1 bit. Asynchronous, active-low reset.
- `data`: input, `WIDTH` bits. Word to transmit; sampled on the handshake.
- `valid`: input, 1 bit. `data` is valid.
- `ready`: output, 1 bit. Transmitter can accept a word.
- `a`: output, 1 bit. Serial output; 0 when not transmitting.
- `busy`: output, 1 bit. High in SHIFT or GAP.
- `done`: output, 1 bit. One-cycle pulse while the last bit of a word is driven.
- `exp_s`, `exp_t`: output, 1 bit each. Expected C4 state. These ports exist only with `C4_TX_MODEL_EN`.

## Operation
- The FSM states are IDLE, SHIFT and GAP.
- IDLE:
  - `ready`=1 and `a`=0.
  - `valid`&&`ready` at an edge loads `data` into a shift register, sets `bit_cnt`=0, and moves to SHIFT.
- SHIFT:
  - `a`=`shreg[0]`, registered.
  - Each edge shifts right and increments `bit_cnt`.
  - On the edge where `bit_cnt`==`WIDTH`-1, the FSM moves to GAP, or to IDLE if `GAP`==0.
- GAP:
  - `a`=0 and `gap_cnt` counts 0..`GAP`-1.
  - The FSM returns to IDLE when `gap_cnt`==`GAP`-1.
- `ready` is high only in IDLE. `valid` outside IDLE is ignored; the word is neither latched nor queued.
- `data` changing after acceptance has no effect.
- `done`=1 exactly in the cycle when bit `WIDTH`-1 is on `a`.
- Counters are sized `$clog2(WIDTH)` and `$clog2(GAP+1)`, with no wrap beyond their terminal values.
- C4 model: `{exp_s,exp_t}` updates every edge from the current `a`:
  - 00/0→00, 00/1→01
  - 01/0→11, 01/1→10
  - 11/x→00
  - 10/0→00, 10/1→10
  - The model runs in all FSM states, including IDLE and GAP.

## Timing
- Reset, asynchronous and effective immediately: state=IDLE, `a`=0, `ready`=1, `busy`=0, `done`=0, shift register and counters 0, `{exp_s,exp_t}`=00.
- Latency: handshake edge k gives bit 0 on `a` after edge k, and bit i after edge k+i.
- The word occupies `WIDTH` cycles.
- Minimum spacing between accepted words is `WIDTH`+`GAP`+1 cycles, because one IDLE cycle is always present.
- Reset mid-word aborts the transfer. No `done` is produced, and the model returns to 00.
- With `GAP`=0, the FSM returns directly from SHIFT to IDLE. `a`=0 for exactly one cycle before the next word.
- `valid` and `rst` deasserting on the same edge: reset wins, so no acceptance occurs on that edge.

## Configuration
- `C4_TX_MODEL_EN` defined: the C4 model is instantiated and `exp_s`/`exp_t` are present.
- Not defined: the model is omitted, the ports are absent, and the transmit behaviour is unchanged.

## Structure
- `c4_pkg` holds:
  - `tx_state_t`, the IDLE/SHIFT/GAP enum.
  - `c4_state_t`, a 2-bit `{s,t}` typedef with named constants S00, S01, S11, S10.
  - A function `c4_next(c4_state_t, logic a)`.
- Sub-module `c4_model`: a registered `{s,t}` using `c4_next`, instantiated only under the macro.

## Test plan
- Reset, then `data`=8'hA5 with `valid` for one cycle:
  - `a` = 1,0,1,0,0,1,0,1 on successive cycles.
  - `done` is high on the 8th bit, then 1 GAP cycle, then `ready`=1.
  - `exp` sequence: 01,11,00,00,00,01,11,00, then 00.
- `data`=8'hFF:
  - `exp` = 01,10,10,10,10,10,10,10.
  - The gap cycle gives 00.
  - Covers the 10/1 self-loop and 10/0→00.
- `valid` held high with 8'h0F then 8'hF0:
  - The second word starts only after the IDLE cycle.
  - `a` reads the 0F bits, 0 for 2 cycles, then the F0 bits.
- `rst` pulsed low during bit 3 of 8'hAA:
  - `a`=0, `busy`=0, `ready`=1, `exp`=00 immediately.
  - No `done` pulse.
- `GAP`=0, `WIDTH`=4, words 4'h1 then 4'h3 back-to-back:
  - `a` = 1,0,0,0,0,1,1,0,0.
  - `done` is high at cycles 4 and 9.
- `valid` pulsed during SHIFT with `data`=8'h55:
  - The pulse is ignored.
  - The current word completes unchanged.
  - No second `done` pulse.
